// File: rtl/meas_window_sched_if.sv
// Result channel of the measurement scheduler: one min/max/channel record per
// completed window, transferred with a valid/ready handshake.
interface meas_window_sched_if #(
    parameter int CW = 2,
    parameter int DW = 12
);
    logic                 result_valid;
    logic                 result_ready;
    logic [CW-1:0]        result_ch;
    logic signed [DW-1:0] result_min;
    logic signed [DW-1:0] result_max;

    modport master (
        output result_valid,
        output result_ch,
        output result_min,
        output result_max,
        input  result_ready
    );

    modport slave (
        input  result_valid,
        input  result_ch,
        input  result_min,
        input  result_max,
        output result_ready
    );
endinterface

// File: rtl/meas_window_sched.sv
// Round-robin scheduler sharing one windowed signed min/max datapath across CH
// sample channels: select, settle, measure win_len samples, report, advance.
module meas_window_sched #(
    parameter int DW     = 12,
    parameter int CH     = 4,
    parameter int CW     = 2,
    parameter int LW     = 10,
    parameter int SETTLE = 2
) (
    input  logic                 clk_in,
    input  logic                 rst,
    input  logic                 run,
    input  logic [CH-1:0]        ch_mask,
    input  logic [LW-1:0]        win_len,
    input  logic [CH*DW-1:0]     data_in,
    output logic [CW-1:0]        ch_sel,
    output logic                 busy,
    meas_window_sched_if.master  res
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SELECT  = 2'd1;
    localparam logic [1:0] ST_MEASURE = 2'd2;
    localparam logic [1:0] ST_REPORT  = 2'd3;

    localparam int SW = (SETTLE > 1) ? $clog2(SETTLE) : 1;

    logic [1:0]           state;
    logic [CW-1:0]        last_ch;
    logic [SW-1:0]        settle_cnt;
    logic [LW-1:0]        len_q;
    logic [LW-1:0]        meas_cnt;
    logic signed [DW-1:0] min_q;
    logic signed [DW-1:0] max_q;
    logic signed [DW-1:0] min_nx;
    logic signed [DW-1:0] max_nx;
    logic signed [DW-1:0] sample;
    logic signed [DW-1:0] lane [CH];
    logic                 start_ok;
    logic [CW-1:0]        base_ch;
    logic [CW-1:0]        next_ch;
    logic                 found;
    int                   idx;

    always_comb begin
        for (int i = 0; i < CH; i++) begin
            lane[i] = data_in[i*DW +: DW];
        end
    end

    assign sample   = lane[ch_sel];
    assign start_ok = run && (win_len != '0) && (ch_mask != '0);
    assign busy     = (state != ST_IDLE);

    // In REPORT the accepted result's channel becomes the new "last" on the
    // same edge, so search from it directly rather than from stale last_ch.
    assign base_ch = (state == ST_REPORT) ? res.result_ch : last_ch;

    always_comb begin
        next_ch = base_ch;
        found   = 1'b0;
        idx     = 0;
        for (int k = 1; k <= CH; k++) begin
            idx = (int'(base_ch) + k) % CH;
            if (!found && ch_mask[CW'(idx)]) begin
                next_ch = CW'(idx);
                found   = 1'b1;
            end
        end
    end

    // First sample of a window seeds both extremes; no zero seed.
    always_comb begin
        if (meas_cnt == '0) begin
            min_nx = sample;
            max_nx = sample;
        end else begin
            min_nx = (sample < min_q) ? sample : min_q;
            max_nx = (sample > max_q) ? sample : max_q;
        end
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state            <= ST_IDLE;
            ch_sel           <= '0;
            last_ch          <= CW'(CH - 1);
            settle_cnt       <= '0;
            len_q            <= '0;
            meas_cnt         <= '0;
            min_q            <= '0;
            max_q            <= '0;
            res.result_valid <= 1'b0;
            res.result_ch    <= '0;
            res.result_min   <= '0;
            res.result_max   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        state      <= ST_SELECT;
                        ch_sel     <= next_ch;
                        settle_cnt <= '0;
                    end
                end
                ST_SELECT: begin
                    if (settle_cnt == SW'(SETTLE - 1)) begin
                        // A window length of zero at latch time means nothing to measure.
                        state    <= (win_len == '0) ? ST_IDLE : ST_MEASURE;
                        len_q    <= win_len;
                        meas_cnt <= '0;
                    end else begin
                        settle_cnt <= settle_cnt + 1'b1;
                    end
                end
                ST_MEASURE: begin
                    min_q <= min_nx;
                    max_q <= max_nx;
                    if (meas_cnt == len_q - 1'b1) begin
                        state            <= ST_REPORT;
                        res.result_valid <= 1'b1;
                        res.result_ch    <= ch_sel;
                        res.result_min   <= min_nx;
                        res.result_max   <= max_nx;
                    end else begin
                        meas_cnt <= meas_cnt + 1'b1;
                    end
                end
                ST_REPORT: begin
                    if (res.result_ready) begin
                        res.result_valid <= 1'b0;
                        last_ch          <= res.result_ch;
                        if (start_ok) begin
                            state      <= ST_SELECT;
                            ch_sel     <= next_ch;
                            settle_cnt <= '0;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_meas_window_sched.sv
// Directed scenarios plus a randomized phase for meas_window_sched, checked every
// cycle against a window-timeline reference model.
module tb_meas_window_sched;

    localparam int DW     = 12;
    localparam int CH     = 4;
    localparam int CW     = 2;
    localparam int LW     = 10;
    localparam int SETTLE = 2;

    logic              clk_in = 1'b0;
    logic              rst;
    logic              run;
    logic [CH-1:0]     ch_mask;
    logic [LW-1:0]     win_len;
    logic [CH*DW-1:0]  data_in;
    logic [CW-1:0]     ch_sel;
    logic              busy;

    meas_window_sched_if #(.CW(CW), .DW(DW)) rif ();

    meas_window_sched #(
        .DW(DW), .CH(CH), .CW(CW), .LW(LW), .SETTLE(SETTLE)
    ) dut (
        .clk_in  (clk_in),
        .rst     (rst),
        .run     (run),
        .ch_mask (ch_mask),
        .win_len (win_len),
        .data_in (data_in),
        .ch_sel  (ch_sel),
        .busy    (busy),
        .res     (rif.master)
    );

    always #5 clk_in = ~clk_in;

    typedef struct {
        int ch;
        int mn;
        int mx;
    } res_t;

    int               tests    = 0;
    int               failures = 0;
    int               cyc      = 0;
    int               pat_mode = 0;
    logic [CH*DW-1:0] hist [int];
    res_t             obs_q [$];

    // Reference model: a window is a timeline anchored at the cycle whose inputs
    // caused the channel selection.
    bit m_active    = 1'b0;
    bit m_reporting = 1'b0;
    int m_ch        = 0;
    int m_last      = CH - 1;
    int m_start     = 0;
    int m_len       = 0;
    int m_rep_cycle = -1;
    int m_min       = 0;
    int m_max       = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    function automatic int lane_of(input logic [CH*DW-1:0] w, input int ch);
        logic [CH*DW-1:0]     s;
        logic signed [DW-1:0] v;
        s = w >> (ch * DW);
        v = s[DW-1:0];
        return int'(v);
    endfunction

    function automatic int spec_next(input int last, input logic [CH-1:0] mask);
        int m;
        m = int'(mask);
        for (int k = 1; k <= CH; k++) begin
            if (((m >> ((last + k) % CH)) & 1) != 0) return (last + k) % CH;
        end
        return last;
    endfunction

    task automatic startWin();
        m_active    = 1'b1;
        m_ch        = spec_next(m_last, ch_mask);
        m_start     = cyc;
        m_rep_cycle = -1;
    endtask

    task automatic modelAdvance();
        bit go;
        go = run && (win_len != '0) && (ch_mask != '0);
        if (m_reporting) begin
            if (rif.result_ready) begin
                m_last      = m_ch;
                m_reporting = 1'b0;
                if (go) startWin();
                else    m_active = 1'b0;
            end
        end else if (!m_active) begin
            if (go) startWin();
        end else if (cyc == m_start + SETTLE) begin
            m_len       = int'(win_len);
            m_rep_cycle = m_start + 1 + SETTLE + m_len;
        end
    endtask

    task automatic checkOutput();
        chk("busy", 32'(busy), 32'(m_active));
        chk("result_valid", 32'(rif.result_valid), 32'(m_reporting));
        if (m_active) chk("ch_sel", 32'(ch_sel), 32'(m_ch));
        if (m_reporting) begin
            chk("result_ch", 32'(rif.result_ch), 32'(m_ch));
            chk("result_min", 32'(rif.result_min), 32'(m_min));
            chk("result_max", 32'(rif.result_max), 32'(m_max));
        end
    endtask

    task automatic applyStimulus();
        logic [CH*DW-1:0] w;
        int               v;
        res_t             r;
        w = '0;
        for (int c = 0; c < CH; c++) begin
            case (pat_mode)
                1: begin
                    if (c == 2) begin
                        case (cyc % 4)
                            0:       v = -3;
                            1:       v = 5;
                            2:       v = -7;
                            default: v = 1;
                        endcase
                    end else begin
                        v = int'($urandom_range(0, 4095)) - 2048;
                    end
                end
                2:       v = 100 + (cyc % 4);
                3:       v = -50;
                default: v = int'($urandom_range(0, 4095)) - 2048;
            endcase
            w = {DW'(v), w[CH*DW-1:DW]};
        end
        data_in   = w;
        hist[cyc] = w;
        if (rif.result_valid && rif.result_ready) begin
            r.ch = int'(rif.result_ch);
            r.mn = int'(rif.result_min);
            r.mx = int'(rif.result_max);
            obs_q.push_back(r);
        end
        modelAdvance();
        @(posedge clk_in);
        #1;
        cyc++;
        if (m_active && !m_reporting && cyc == m_rep_cycle) begin
            m_min = lane_of(hist[m_start + 1 + SETTLE], m_ch);
            m_max = m_min;
            for (int j = 1; j < m_len; j++) begin
                v = lane_of(hist[m_start + 1 + SETTLE + j], m_ch);
                if (v < m_min) m_min = v;
                if (v > m_max) m_max = v;
            end
            m_reporting = 1'b1;
        end
        checkOutput();
    endtask

    task automatic doReset();
        rst = 1'b1;
        #1;
        m_active    = 1'b0;
        m_reporting = 1'b0;
        m_last      = CH - 1;
        m_rep_cycle = -1;
        chk("rst_busy", 32'(busy), 32'(0));
        chk("rst_valid", 32'(rif.result_valid), 32'(0));
        chk("rst_ch_sel", 32'(ch_sel), 32'(0));
        chk("rst_result_ch", 32'(rif.result_ch), 32'(0));
        chk("rst_result_min", 32'(rif.result_min), 32'(0));
        chk("rst_result_max", 32'(rif.result_max), 32'(0));
        @(posedge clk_in);
        #1;
        cyc++;
        rst = 1'b0;
    endtask

    task automatic waitResults(input int n, input int budget);
        int k;
        k = 0;
        while (obs_q.size() < n && k < budget) begin
            applyStimulus();
            k++;
        end
        chk("result_count", 32'(obs_q.size()), 32'(n));
    endtask

    task automatic waitIdle(input int budget);
        int k;
        k = 0;
        while (m_active && k < budget) begin
            applyStimulus();
            k++;
        end
        chk("idle_busy", 32'(busy), 32'(0));
    endtask

    int seq1 [5] = '{0, 1, 2, 3, 0};
    int seq2 [4] = '{3, 1, 3, 1};

    initial begin
        int k;
        rst              = 1'b1;
        run              = 1'b0;
        ch_mask          = '0;
        win_len          = '0;
        data_in          = '0;
        rif.result_ready = 1'b0;
        doReset();

        // Full mask: round-robin from channel 0, ch2 sees -3,5,-7,1.
        ch_mask = 4'b1111; win_len = 10'd4; rif.result_ready = 1'b1; pat_mode = 1; run = 1'b1;
        obs_q.delete();
        waitResults(5, 200);
        for (int i = 0; i < obs_q.size(); i++) chk("t1_seq", 32'(obs_q[i].ch), 32'(seq1[i]));
        if (obs_q.size() >= 3) begin
            chk("t1_ch2_min", 32'(obs_q[2].mn), 32'(-7));
            chk("t1_ch2_max", 32'(obs_q[2].mx), 32'(5));
        end
        // Run dropped while channel 1 is in flight: exactly one more result.
        run = 1'b0;
        obs_q.delete();
        waitIdle(100);
        chk("t5_drain_count", 32'(obs_q.size()), 32'(1));
        if (obs_q.size() >= 1) chk("t5_drain_ch", 32'(obs_q[0].ch), 32'(1));

        ch_mask = 4'b1010; pat_mode = 0; run = 1'b1;
        obs_q.delete();
        waitResults(4, 200);
        for (int i = 0; i < obs_q.size(); i++) chk("t2_seq", 32'(obs_q[i].ch), 32'(seq2[i]));
        run = 1'b0;
        waitIdle(100);

        // Single channel, back to back; positive then constant negative data.
        ch_mask = 4'b0001; pat_mode = 2; run = 1'b1;
        obs_q.delete();
        waitResults(2, 100);
        for (int i = 0; i < obs_q.size(); i++) begin
            chk("t3_pos_ch", 32'(obs_q[i].ch), 32'(0));
            chk("t3_pos_min", 32'(obs_q[i].mn), 32'(100));
            chk("t3_pos_max", 32'(obs_q[i].mx), 32'(103));
        end
        run = 1'b0;
        waitIdle(100);
        pat_mode = 3; run = 1'b1;
        obs_q.delete();
        waitResults(2, 100);
        for (int i = 0; i < obs_q.size(); i++) begin
            chk("t3_neg_min", 32'(obs_q[i].mn), 32'(-50));
            chk("t3_neg_max", 32'(obs_q[i].mx), 32'(-50));
        end
        run = 1'b0;
        waitIdle(100);

        // Consumer stall for 20 cycles; win_len changed during the stall.
        ch_mask = 4'b1111; pat_mode = 0; rif.result_ready = 1'b0; run = 1'b1;
        k = 0;
        while (!m_reporting && k < 100) begin
            applyStimulus();
            k++;
        end
        chk("t4_in_report", 32'(rif.result_valid), 32'(1));
        win_len = 10'd6;
        for (int i = 0; i < 20; i++) applyStimulus();
        rif.result_ready = 1'b1;
        obs_q.delete();
        waitResults(2, 100);
        run = 1'b0;
        waitIdle(100);

        // Disabled configurations never leave IDLE.
        win_len = 10'd0; run = 1'b1;
        for (int i = 0; i < 30; i++) applyStimulus();
        chk("t5_len0_busy", 32'(busy), 32'(0));
        win_len = 10'd4; ch_mask = 4'b0000;
        for (int i = 0; i < 30; i++) applyStimulus();
        chk("t5_mask0_busy", 32'(busy), 32'(0));

        // Reset in the middle of a measurement window.
        ch_mask = 4'b1111; win_len = 10'd8;
        k = 0;
        while (!(m_active && m_rep_cycle > 0 && cyc >= m_start + SETTLE + 3) && k < 100) begin
            applyStimulus();
            k++;
        end
        chk("t6_busy_before", 32'(busy), 32'(1));
        doReset();
        obs_q.delete();
        waitResults(1, 100);
        if (obs_q.size() >= 1) chk("t6_restart_ch", 32'(obs_q[0].ch), 32'(0));

        // Randomized traffic.
        win_len = 10'd3;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) < 3) run = ~run;
            if ($urandom_range(0, 99) < 5) ch_mask = 4'($urandom);
            if ($urandom_range(0, 99) < 5) win_len = 10'($urandom_range(1, 6));
            rif.result_ready = ($urandom_range(0, 99) < 70);
            applyStimulus();
        end
        run = 1'b0;
        rif.result_ready = 1'b1;
        waitIdle(200);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
